mio_clk_div: RTL and testbench



---
 rtl/mio_clk_div_pkg.sv | 18 +
 rtl/mio_clk_div_cfg.sv | 79 +++++++
 rtl/mio_clk_div.sv | 112 +++++++++++
 tb/tb_mio_clk_div.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mio_clk_div_pkg.sv
// Shared types and helpers for the programmable divided-clock generator.
package mio_clk_div_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } mio_clk_div_state_t;

    // A waveform needs at least one low and one high cycle per period.
    function automatic logic mio_clk_div_cfg_legal(input logic [MAX_W-1:0] per,
                                                   input logic [MAX_W-1:0] high);
        return (per >= MAX_W'(2)) && (high >= MAX_W'(1)) && (high < per);
    endfunction

endpackage

// File: rtl/mio_clk_div_cfg.sv
// Configuration path: valid/ready intake, legality check, one-deep shadow and active {period, high}.
module mio_clk_div_cfg
    import mio_clk_div_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 4,
    parameter int DEF_HIGH   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    input  logic             idle,
    input  logic             apply,
    output logic [CNT_W-1:0] act_high,
    output logic [CNT_W-1:0] eff_per,
    output logic [CNT_W-1:0] eff_high
);

    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] sh_per;
    logic [CNT_W-1:0] sh_high;
    logic             sh_vld;
    logic             accept;
    logic             legal;
    logic             take;

    // Handshake: a transfer occurs when cfg_valid && cfg_ready; ready only while the shadow is empty.
    assign cfg_ready = !sh_vld;
    assign accept    = cfg_valid && cfg_ready;
    assign legal     = mio_clk_div_cfg_legal(MAX_W'(cfg_period), MAX_W'(cfg_high));
    assign take      = accept && legal;
    assign act_high  = high;

    // Values the active registers hold after an apply; a config taken in the apply cycle writes through.
    always_comb begin
        eff_per  = per;
        eff_high = high;
        if (sh_vld) begin
            eff_per  = sh_per;
            eff_high = sh_high;
        end else if (take) begin
            eff_per  = cfg_period;
            eff_high = cfg_high;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per     <= CNT_W'(DEF_PERIOD);
            high    <= CNT_W'(DEF_HIGH);
            sh_per  <= '0;
            sh_high <= '0;
            sh_vld  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && !legal;
            if (apply) begin
                per    <= eff_per;
                high   <= eff_high;
                sh_vld <= 1'b0;
            end else if (take) begin
                if (idle) begin
                    per  <= cfg_period;
                    high <= cfg_high;
                end else begin
                    sh_per  <= cfg_period;
                    sh_high <= cfg_high;
                    sh_vld  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mio_clk_div.sv
// Glitch-free programmable clock divider: registered div_clk with edge strobes and clean start/stop.
module mio_clk_div
    import mio_clk_div_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 4,
    parameter int DEF_HIGH   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    output logic             div_clk,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             running
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    mio_clk_div_state_t state;
    logic [CNT_W-1:0]   cnt;
    logic               stop_pend;
    logic               start_go;
    logic               boundary;
    logic               apply;
    logic [CNT_W-1:0]   act_high;
    logic [CNT_W-1:0]   eff_per;
    logic [CNT_W-1:0]   eff_high;

    assign start_go = (state == ST_IDLE) && start && !stop;
    assign boundary = (state == ST_HIGH) && (cnt == '0) && !(stop_pend || stop);
    assign apply    = start_go || boundary;
    assign running  = (state != ST_IDLE);

    mio_clk_div_cfg #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_HIGH   (DEF_HIGH)
    ) u_cfg (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_err    (cfg_err),
        .idle       (state == ST_IDLE),
        .apply      (apply),
        .act_high   (act_high),
        .eff_per    (eff_per),
        .eff_high   (eff_high)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            stop_pend <= 1'b0;
            div_clk   <= 1'b0;
            rise_stb  <= 1'b0;
            fall_stb  <= 1'b0;
        end else begin
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    stop_pend <= 1'b0;
                    if (start_go) begin
                        state <= ST_LOW;
                        cnt   <= eff_per - eff_high - ONE;
                    end
                end
                ST_LOW: begin
                    if (stop) stop_pend <= 1'b1;
                    if (cnt == '0) begin
                        state    <= ST_HIGH;
                        cnt      <= act_high - ONE;
                        div_clk  <= 1'b1;
                        rise_stb <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                ST_HIGH: begin
                    if (stop) stop_pend <= 1'b1;
                    if (cnt == '0) begin
                        div_clk  <= 1'b0;
                        fall_stb <= 1'b1;
                        // A stop arriving in the last high cycle still ends the waveform at this edge.
                        if (stop_pend || stop) begin
                            state     <= ST_IDLE;
                            stop_pend <= 1'b0;
                        end else begin
                            state <= ST_LOW;
                            cnt   <= eff_per - eff_high - ONE;
                        end
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_clk_div.sv
// Self-checking bench for mio_clk_div: directed scenarios then random traffic against a period-position model.
module tb_mio_clk_div;

    localparam int CNT_W      = 16;
    localparam int DEF_PERIOD = 4;
    localparam int DEF_HIGH   = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_high = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             div_clk;
    logic             rise_stb;
    logic             fall_stb;
    logic             running;

    int checks = 0;
    int errors = 0;

    mio_clk_div #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_HIGH   (DEF_HIGH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_err    (cfg_err),
        .start      (start),
        .stop       (stop),
        .div_clk    (div_clk),
        .rise_stb   (rise_stb),
        .fall_stb   (fall_stb),
        .running    (running)
    );

    always #5 clk = ~clk;

    // Reference model: position within the current period, counted up from the LOW entry.
    bit m_run, m_stop, m_sv, m_div, m_prev, m_err;
    int m_pos, m_per, m_high, m_sper, m_shigh;

    function automatic void model_reset();
        m_run = 0; m_stop = 0; m_sv = 0; m_div = 0; m_prev = 0; m_err = 0;
        m_pos = 0; m_per = DEF_PERIOD; m_high = DEF_HIGH; m_sper = 0; m_shigh = 0;
    endfunction

    function automatic void model_edge(input bit cv, input int cp, input int ch,
                                       input bit st, input bit sp);
        bit was_run, acc, legal, take, app, go_idle;
        int np, nh;
        was_run = m_run;
        acc     = cv && !m_sv;
        legal   = (cp >= 2) && (ch >= 1) && (ch < cp);
        take    = acc && legal;
        app     = 0;
        go_idle = 0;
        np = m_per;
        nh = m_high;
        if (m_sv) begin
            np = m_sper; nh = m_shigh;
        end else if (take) begin
            np = cp; nh = ch;
        end
        m_err  = acc && !legal;
        m_prev = m_div;
        if (!was_run) begin
            if (st && !sp) begin
                app = 1; m_run = 1; m_pos = 0;
            end
        end else if (m_pos == m_per - 1) begin
            if (m_stop || sp) go_idle = 1;
            else begin
                app = 1; m_pos = 0;
            end
        end else begin
            m_pos++;
        end
        if (app) begin
            m_per = np; m_high = nh; m_sv = 0;
        end else if (take) begin
            if (!was_run) begin
                m_per = cp; m_high = ch;
            end else begin
                m_sper = cp; m_shigh = ch; m_sv = 1;
            end
        end
        if (go_idle) begin
            m_run = 0; m_stop = 0;
        end else if (was_run && sp) begin
            m_stop = 1;
        end
        m_div = m_run && (m_pos >= m_per - m_high);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("div_clk",   div_clk,   m_div);
        chk("rise_stb",  rise_stb,  m_div && !m_prev);
        chk("fall_stb",  fall_stb,  !m_div && m_prev);
        chk("running",   running,   m_run);
        chk("cfg_ready", cfg_ready, !m_sv);
        chk("cfg_err",   cfg_err,   m_err);
    endtask

    task automatic step(input bit cv, input int cp, input int ch, input bit st, input bit sp);
        cfg_valid  = cv;
        cfg_period = CNT_W'(cp);
        cfg_high   = CNT_W'(ch);
        start      = st;
        stop       = sp;
        @(posedge clk);
        model_edge(cv, cp, ch, st, sp);
        #1;
        check_outputs();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic align_pos(input int p);
        for (int i = 0; i < 64; i++) begin
            if (m_run && m_pos == p) break;
            step(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        model_edge(0, 0, 0, 0, 0);
        #1;
        check_outputs();

        // Default 4/2 waveform from a start pulse.
        step(0, 0, 0, 1, 0);
        idle_steps(12);

        // Legal config mid-LOW lands in the shadow and applies at the next boundary.
        align_pos(0);
        step(0, 0, 0, 0, 0);
        step(1, 5, 1, 0, 0);
        idle_steps(14);

        // Illegal configs pulse cfg_err and leave the waveform alone.
        step(1, 3, 3, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        idle_steps(8);

        // Stop during the first LOW cycle of a period.
        align_pos(0);
        step(0, 0, 0, 0, 1);
        idle_steps(10);

        // start with stop in IDLE stays idle.
        step(0, 0, 0, 1, 1);
        idle_steps(4);

        // Stop and shadow pending at the same boundary: shadow survives to the next start.
        step(0, 0, 0, 1, 0);
        step(1, 6, 3, 0, 1);
        idle_steps(10);
        step(0, 0, 0, 1, 0);
        idle_steps(14);

        // Asynchronous reset in the middle of HIGH.
        align_pos(4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_div_clk", div_clk, 1'b0);
        chk("async_running", running, 1'b0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        model_edge(0, 0, 0, 0, 0);
        #1;
        check_outputs();
        step(0, 0, 0, 1, 0);
        idle_steps(12);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) < 3,
                 int'($urandom_range(0, 10)),
                 int'($urandom_range(0, 10)),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 39) == 0);
        end
        idle_steps(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
